// File: rtl/conv_layer_scheduler_if.sv
// rtl/conv_layer_scheduler_if.sv - handshake bundle between the layer scheduler and its datapath
//
// Purpose: groups the sample handshake, conv engine control, cache strobes and
// status of conv_layer_scheduler into one interface.
// Signals:
//   in_v / in_rdy        sample handshake (accepted when both high)
//   lsb_shift            strobe: shift sample into the input left-shift buffer
//   eng_start            strobe: engine starts layer eng_layer
//   eng_layer, eng_relu  layer select and ReLU enable for the engine
//   eng_done             engine result valid (pulse or level)
//   cache_shift          one-hot per-layer activation cache push
//   out_v                final-layer output valid pulse
//   busy, err            not idle / sticky engine timeout
//   sample_count         completed samples, wraps at 16 bits
// Modports: master = scheduler side, slave = sample source + datapath side.
interface conv_layer_scheduler_if #(
  parameter int NUM_LAYERS = 3,
  parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
);
  logic                  in_v;
  logic                  in_rdy;
  logic                  lsb_shift;
  logic                  eng_start;
  logic [LW-1:0]         eng_layer;
  logic                  eng_relu;
  logic                  eng_done;
  logic [NUM_LAYERS-1:0] cache_shift;
  logic                  out_v;
  logic                  busy;
  logic                  err;
  logic [15:0]           sample_count;

  modport master (
    input  in_v, eng_done,
    output in_rdy, lsb_shift, eng_start, eng_layer, eng_relu,
           cache_shift, out_v, busy, err, sample_count
  );

  modport slave (
    output in_v, eng_done,
    input  in_rdy, lsb_shift, eng_start, eng_layer, eng_relu,
           cache_shift, out_v, busy, err, sample_count
  );
endinterface

// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - time-shares one conv1d engine across stacked dilated causal layers
//
// Purpose: per accepted sample, strobes the input shift buffer, runs the engine
// once per layer (waiting for its done), pushes each layer result into that
// layer's activation caches and finally flags the network output valid.
// An engine that stays silent for MAX_WAIT cycles aborts the sample and sets
// a sticky error.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  conv_layer_scheduler_if master modport (see interface header)
module conv_layer_scheduler #(
  parameter int W          = 16,
  parameter int NUM_LAYERS = 3,
  parameter int MAX_WAIT   = 255,
  parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input logic                    clk,
  input logic                    rst,
  conv_layer_scheduler_if.master bus
);

  // Elaboration-time guard on the supported parameter ranges.
  if (W < 1 || NUM_LAYERS < 1 || NUM_LAYERS > 8 || MAX_WAIT < 1 || MAX_WAIT > 65535) begin : g_bad_params
    $error("conv_layer_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_EMIT
  } state_t;

  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [15:0]   WAIT_LAST  = 16'(MAX_WAIT - 1);

  state_t                r_state;
  logic [LW-1:0]         r_l;
  logic [15:0]           r_wait;
  logic [15:0]           r_sample_count;
  logic                  r_err;
  logic                  r_in_rdy;
  logic                  r_busy;
  logic                  r_lsb_shift;
  logic                  r_eng_start;
  logic [NUM_LAYERS-1:0] r_cache_shift;
  logic                  r_out_v;

  // Outputs are registered alongside the state transition so each one is
  // high exactly while the FSM sits in its decoding state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_l            <= '0;
      r_wait         <= '0;
      r_sample_count <= '0;
      r_err          <= 1'b0;
      r_in_rdy       <= 1'b1;
      r_busy         <= 1'b0;
      r_lsb_shift    <= 1'b0;
      r_eng_start    <= 1'b0;
      r_cache_shift  <= '0;
      r_out_v        <= 1'b0;
    end else begin
      r_lsb_shift   <= 1'b0;
      r_eng_start   <= 1'b0;
      r_cache_shift <= '0;
      r_out_v       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_l <= '0;
          if (bus.in_v) begin
            r_state     <= S_LOAD;
            r_in_rdy    <= 1'b0;
            r_busy      <= 1'b1;
            r_lsb_shift <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state     <= S_START;
          r_eng_start <= 1'b1;
        end
        S_START: begin
          r_state <= S_WAIT;
          r_wait  <= '0;
        end
        S_WAIT: begin
          if (bus.eng_done) begin
            r_state       <= S_CAPTURE;
            r_cache_shift <= NUM_LAYERS'(1) << r_l;
          end else if (r_wait == WAIT_LAST) begin
            // Abort the sample: no cache push or output for it.
            r_state  <= S_IDLE;
            r_err    <= 1'b1;
            r_l      <= '0;
            r_in_rdy <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        S_CAPTURE: begin
          if (r_l == LAST_LAYER) begin
            r_state <= S_EMIT;
            r_out_v <= 1'b1;
          end else begin
            r_l         <= r_l + LW'(1);
            r_state     <= S_START;
            r_eng_start <= 1'b1;
          end
        end
        S_EMIT: begin
          r_sample_count <= r_sample_count + 16'd1;
          r_l            <= '0;
          r_state        <= S_IDLE;
          r_in_rdy       <= 1'b1;
          r_busy         <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_l      <= '0;
          r_in_rdy <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_rdy       = r_in_rdy;
  assign bus.busy         = r_busy;
  assign bus.lsb_shift    = r_lsb_shift;
  assign bus.eng_start    = r_eng_start;
  assign bus.eng_layer    = r_l;
  assign bus.eng_relu     = (r_l != LAST_LAYER);
  assign bus.cache_shift  = r_cache_shift;
  assign bus.out_v        = r_out_v;
  assign bus.err          = r_err;
  assign bus.sample_count = r_sample_count;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb/tb_conv_layer_scheduler.sv - directed self-checking bench for conv_layer_scheduler
module tb_conv_layer_scheduler;
  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_layer_scheduler_if #(.NUM_LAYERS(NL)) a_if ();
  conv_layer_scheduler_if #(.NUM_LAYERS(NL)) b_if ();

  conv_layer_scheduler #(.W(16), .NUM_LAYERS(NL), .MAX_WAIT(255)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  conv_layer_scheduler #(.W(16), .NUM_LAYERS(NL), .MAX_WAIT(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine models: after eng_start, done pulses dly[layer] cycles after the
  // first WAIT cycle; a negative delay means the engine never answers.
  int dly_a[NL];
  int dly_b[NL];
  bit arm_a, arm_b, d_a, d_b, spur;
  int cnt_a, cnt_b;

  always @(negedge clk) begin
    if (rst) begin
      arm_a = 1'b0;
      a_if.eng_done = 1'b0;
    end else begin
      d_a = 1'b0;
      if (arm_a) begin
        if (cnt_a == 0) begin d_a = 1'b1; arm_a = 1'b0; end
        else cnt_a--;
      end
      if (a_if.eng_start && dly_a[a_if.eng_layer] >= 0) begin
        arm_a = 1'b1;
        cnt_a = dly_a[a_if.eng_layer];
      end
      if (spur && (a_if.cache_shift != '0 || a_if.in_rdy)) d_a = 1'b1;
      a_if.eng_done = d_a;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      arm_b = 1'b0;
      b_if.eng_done = 1'b0;
    end else begin
      d_b = 1'b0;
      if (arm_b) begin
        if (cnt_b == 0) begin d_b = 1'b1; arm_b = 1'b0; end
        else cnt_b--;
      end
      if (b_if.eng_start && dly_b[b_if.eng_layer] >= 0) begin
        arm_b = 1'b1;
        cnt_b = dly_b[b_if.eng_layer];
      end
      b_if.eng_done = d_b;
    end
  end

  // Event logs, cycle numbers relative to the cycle in which in_v is sampled.
  int lsb_q[$], st_q[$], ly_q[$], rl_q[$], ch_q[$], cv_q[$], ov_q[$];
  int chb_q[$], cvb_q[$], ovb_q[$];
  int rdy_at, errb_at, rdyb_at_err;

  always @(negedge clk) begin
    if (a_if.lsb_shift) lsb_q.push_back(cyc - t0);
    if (a_if.eng_start) begin
      st_q.push_back(cyc - t0);
      ly_q.push_back(int'(a_if.eng_layer));
      rl_q.push_back(int'(a_if.eng_relu));
    end
    if (a_if.cache_shift != '0) begin
      ch_q.push_back(cyc - t0);
      cv_q.push_back(int'(a_if.cache_shift));
    end
    if (a_if.out_v) ov_q.push_back(cyc - t0);
    if (a_if.in_rdy && rdy_at < 0 && (cyc - t0) > 1) rdy_at = cyc - t0;
    if (b_if.cache_shift != '0) begin
      chb_q.push_back(cyc - t0);
      cvb_q.push_back(int'(b_if.cache_shift));
    end
    if (b_if.out_v) ovb_q.push_back(cyc - t0);
    if (b_if.err && errb_at < 0) begin
      errb_at     = cyc - t0;
      rdyb_at_err = int'(b_if.in_rdy);
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    lsb_q.delete(); st_q.delete(); ly_q.delete(); rl_q.delete();
    ch_q.delete(); cv_q.delete(); ov_q.delete();
    chb_q.delete(); cvb_q.delete(); ovb_q.delete();
    rdy_at = -1;
    errb_at = -1;
  endtask

  task automatic kick_a(input bit hold);
    @(negedge clk);
    clear_logs();
    t0 = cyc;
    a_if.in_v = 1'b1;
    if (!hold) begin
      @(negedge clk);
      a_if.in_v = 1'b0;
    end
  endtask

  task automatic kick_b();
    @(negedge clk);
    clear_logs();
    t0 = cyc;
    b_if.in_v = 1'b1;
    @(negedge clk);
    b_if.in_v = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run_cycles(3);
    rst = 1'b0;
    #1;
    n_vec++; if (a_if.in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy: got %b expected 1", a_if.in_rdy); end
    n_vec++; if (a_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", a_if.busy); end
    n_vec++; if (a_if.err !== 1'b0 || b_if.err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b/%b expected 0/0", a_if.err, b_if.err); end
    n_vec++; if (a_if.sample_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", a_if.sample_count); end
    n_vec++; if ({a_if.lsb_shift, a_if.eng_start, a_if.out_v, a_if.cache_shift} !== 6'b0) begin n_err++; $display("FAIL reset_strobes: got %b expected 000000", {a_if.lsb_shift, a_if.eng_start, a_if.out_v, a_if.cache_shift}); end
    n_vec++; if (a_if.eng_layer !== 2'd0 || a_if.eng_relu !== 1'b1) begin n_err++; $display("FAIL reset_layer: got layer %0d relu %b expected 0 1", a_if.eng_layer, a_if.eng_relu); end
  endtask

  task automatic test_single();
    int e_st[3], e_ly[3], e_rl[3], e_ch[3], e_cv[3];
    e_st = '{2, 5, 8}; e_ly = '{0, 1, 2}; e_rl = '{1, 1, 0};
    e_ch = '{4, 7, 10}; e_cv = '{1, 2, 4};
    dly_a = '{0, 0, 0};
    kick_a(1'b0);
    run_cycles(14);
    #1;
    n_vec++; if (lsb_q.size() != 1 || lsb_q[0] !== 1) begin n_err++; $display("FAIL single_lsb: got %0d events first %0d expected 1 event at 1", lsb_q.size(), (lsb_q.size() > 0) ? lsb_q[0] : -1); end
    n_vec++;
    if (st_q.size() != 3) begin n_err++; $display("FAIL single_start_count: got %0d expected 3", st_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (st_q[i] !== e_st[i] || ly_q[i] !== e_ly[i] || rl_q[i] !== e_rl[i]) begin
        n_err++; $display("FAIL single_start%0d: got cyc %0d layer %0d relu %0d expected %0d %0d %0d", i, st_q[i], ly_q[i], rl_q[i], e_st[i], e_ly[i], e_rl[i]);
      end
    end
    n_vec++;
    if (ch_q.size() != 3) begin n_err++; $display("FAIL single_cache_count: got %0d expected 3", ch_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ch_q[i] !== e_ch[i] || cv_q[i] !== e_cv[i]) begin
        n_err++; $display("FAIL single_cache%0d: got cyc %0d val %0d expected %0d %0d", i, ch_q[i], cv_q[i], e_ch[i], e_cv[i]);
      end
    end
    n_vec++; if (ov_q.size() != 1 || ov_q[0] !== 11) begin n_err++; $display("FAIL single_out_v: got %0d events first %0d expected 1 at 11", ov_q.size(), (ov_q.size() > 0) ? ov_q[0] : -1); end
    n_vec++; if (rdy_at !== 12) begin n_err++; $display("FAIL single_in_rdy_back: got %0d expected 12", rdy_at); end
    n_vec++; if (a_if.sample_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d expected 1", a_if.sample_count); end
  endtask

  task automatic test_delay();
    int e_st[3], e_ch[3];
    e_st = '{2, 5, 13}; e_ch = '{4, 12, 15};
    dly_a = '{0, 5, 0};
    kick_a(1'b0);
    run_cycles(18);
    #1;
    n_vec++; if (lsb_q.size() != 1) begin n_err++; $display("FAIL delay_lsb_count: got %0d expected 1", lsb_q.size()); end
    n_vec++;
    if (st_q.size() != 3 || ch_q.size() != 3) begin n_err++; $display("FAIL delay_counts: got starts %0d caches %0d expected 3 3", st_q.size(), ch_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (st_q[i] !== e_st[i] || ch_q[i] !== e_ch[i]) begin
        n_err++; $display("FAIL delay_layer%0d: got start %0d cache %0d expected %0d %0d", i, st_q[i], ch_q[i], e_st[i], e_ch[i]);
      end
    end
    n_vec++; if (ov_q.size() != 1 || ov_q[0] !== 16) begin n_err++; $display("FAIL delay_out_v: got %0d events first %0d expected 1 at 16", ov_q.size(), (ov_q.size() > 0) ? ov_q[0] : -1); end
    n_vec++; if (a_if.sample_count !== 16'd2) begin n_err++; $display("FAIL delay_count: got %0d expected 2", a_if.sample_count); end
  endtask

  task automatic test_timeout();
    dly_b = '{0, 0, -1};
    kick_b();
    run_cycles(19);
    #1;
    n_vec++; if (chb_q.size() != 2) begin n_err++; $display("FAIL timeout_cache_count: got %0d expected 2", chb_q.size()); end
    else begin
      n_vec++; if (chb_q[0] !== 4 || cvb_q[0] !== 1 || chb_q[1] !== 7 || cvb_q[1] !== 2) begin n_err++; $display("FAIL timeout_caches: got %0d:%0d %0d:%0d expected 4:1 7:2", chb_q[0], cvb_q[0], chb_q[1], cvb_q[1]); end
    end
    n_vec++; if (ovb_q.size() != 0) begin n_err++; $display("FAIL timeout_out_v: got %0d events expected 0", ovb_q.size()); end
    n_vec++; if (errb_at !== 13 || rdyb_at_err !== 1) begin n_err++; $display("FAIL timeout_err_rise: got cyc %0d in_rdy %0d expected 13 1", errb_at, rdyb_at_err); end
    n_vec++; if (b_if.sample_count !== 16'd0) begin n_err++; $display("FAIL timeout_count: got %0d expected 0", b_if.sample_count); end
    dly_b = '{0, 0, 0};
    kick_b();
    run_cycles(14);
    #1;
    n_vec++; if (ovb_q.size() != 1 || ovb_q[0] !== 11) begin n_err++; $display("FAIL timeout_recover_out_v: got %0d events first %0d expected 1 at 11", ovb_q.size(), (ovb_q.size() > 0) ? ovb_q[0] : -1); end
    n_vec++; if (b_if.err !== 1'b1) begin n_err++; $display("FAIL timeout_err_sticky: got %b expected 1", b_if.err); end
    n_vec++; if (b_if.sample_count !== 16'd1) begin n_err++; $display("FAIL timeout_recover_count: got %0d expected 1", b_if.sample_count); end
  endtask

  task automatic test_back_to_back();
    int e_ov[4], e_lsb[4];
    e_ov = '{11, 23, 35, 47}; e_lsb = '{1, 13, 25, 37};
    dly_a = '{0, 0, 0};
    spur = 1'b1;
    kick_a(1'b1);
    run_cycles(47);
    a_if.in_v = 1'b0;
    run_cycles(5);
    spur = 1'b0;
    #1;
    n_vec++;
    if (ov_q.size() != 4 || lsb_q.size() != 4) begin n_err++; $display("FAIL b2b_counts: got out_v %0d lsb %0d expected 4 4", ov_q.size(), lsb_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (ov_q[i] !== e_ov[i] || lsb_q[i] !== e_lsb[i]) begin
        n_err++; $display("FAIL b2b_sample%0d: got out_v %0d lsb %0d expected %0d %0d", i, ov_q[i], lsb_q[i], e_ov[i], e_lsb[i]);
      end
    end
    n_vec++; if (st_q.size() != 12 || ch_q.size() != 12) begin n_err++; $display("FAIL b2b_strobes: got starts %0d caches %0d expected 12 12", st_q.size(), ch_q.size()); end
    n_vec++; if (a_if.sample_count !== 16'd6) begin n_err++; $display("FAIL b2b_count: got %0d expected 6", a_if.sample_count); end
  endtask

  task automatic test_reset_mid_wait();
    dly_a = '{0, -1, 0};
    kick_a(1'b0);
    run_cycles(7);
    rst = 1'b1;
    #1;
    n_vec++; if ({a_if.busy, a_if.lsb_shift, a_if.eng_start, a_if.out_v, a_if.cache_shift} !== 7'b0) begin n_err++; $display("FAIL midrst_outputs: got %b expected 0000000", {a_if.busy, a_if.lsb_shift, a_if.eng_start, a_if.out_v, a_if.cache_shift}); end
    n_vec++; if (a_if.sample_count !== 16'd0 || a_if.eng_layer !== 2'd0) begin n_err++; $display("FAIL midrst_state: got count %0d layer %0d expected 0 0", a_if.sample_count, a_if.eng_layer); end
    n_vec++; if (a_if.err !== 1'b0 || b_if.err !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b/%b expected 0/0", a_if.err, b_if.err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (a_if.in_rdy !== 1'b1) begin n_err++; $display("FAIL midrst_in_rdy: got %b expected 1", a_if.in_rdy); end
    dly_a = '{0, 0, 0};
    kick_a(1'b0);
    run_cycles(14);
    #1;
    n_vec++; if (st_q.size() == 0 || st_q[0] !== 2 || ly_q[0] !== 0) begin n_err++; $display("FAIL midrst_restart: got %0d starts first cyc %0d expected layer 0 at 2", st_q.size(), (st_q.size() > 0) ? st_q[0] : -1); end
    n_vec++; if (ch_q.size() != 3 || cv_q[0] !== 1) begin n_err++; $display("FAIL midrst_caches: got %0d caches expected 3 starting with 001", ch_q.size()); end
    n_vec++; if (ov_q.size() != 1 || ov_q[0] !== 11) begin n_err++; $display("FAIL midrst_out_v: got %0d events expected 1 at 11", ov_q.size()); end
    n_vec++; if (a_if.sample_count !== 16'd1) begin n_err++; $display("FAIL midrst_count: got %0d expected 1", a_if.sample_count); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force u_dut_a.r_sample_count = 16'hFFFF;
    @(negedge clk);
    release u_dut_a.r_sample_count;
    #1;
    n_vec++; if (a_if.sample_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %0d expected 65535", a_if.sample_count); end
    dly_a = '{0, 0, 0};
    kick_a(1'b0);
    run_cycles(14);
    #1;
    n_vec++; if (ov_q.size() != 1 || ov_q[0] !== 11) begin n_err++; $display("FAIL wrap_out_v: got %0d events expected 1 at 11", ov_q.size()); end
    n_vec++; if (a_if.sample_count !== 16'd0) begin n_err++; $display("FAIL wrap_count: got %0d expected 0", a_if.sample_count); end
  endtask

  initial begin
    a_if.in_v = 1'b0;
    b_if.in_v = 1'b0;
    spur = 1'b0;
    dly_a = '{0, 0, 0};
    dly_b = '{0, 0, 0};
    clear_logs();
    test_reset();
    test_single();
    test_delay();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
